// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, buffers in-order responses
// with their PCs, and presents them to decode; redirects flush the buffer and squash stale reads.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_error
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [CntW:0]   DepthCnt = (CntW + 1)'(FIFO_DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            fetch_error_q, fetch_error_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [CntW-1:0] discard_q, discard_d;
    logic [CntW-1:0] fifo_count_q, fifo_count_d;
    logic [PtrW-1:0] fifo_rd_q, fifo_rd_d;
    logic [PtrW-1:0] fifo_wr_q, fifo_wr_d;
    logic [PtrW-1:0] tag_rd_q, tag_rd_d;
    logic [PtrW-1:0] tag_wr_q, tag_wr_d;

    logic [31:0] fifo_data_q [FIFO_DEPTH];
    logic [31:0] fifo_pc_q   [FIFO_DEPTH];
    logic [31:0] tag_pc_q    [FIFO_DEPTH];

    logic [CntW:0] occupancy;
    logic          req_fire;
    logic          rsp_keep;
    logic          instr_pop;

    // Requests in flight plus buffered entries never exceed the buffer size, so every
    // response that is kept always finds a free slot.
    assign occupancy      = {1'b0, inflight_q} + {1'b0, fifo_count_q};
    assign imem_req_valid = resetn && !redirect_valid && !fetch_error_q && (occupancy < DepthCnt);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid = resetn && !fetch_error_q && (fifo_count_q != '0);
    assign instruction = fifo_data_q[fifo_rd_q];
    assign instr_pc    = fifo_pc_q[fifo_rd_q];
    assign fetch_error = fetch_error_q;

    assign rsp_keep  = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    assign instr_pop = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        fetch_error_d = fetch_error_q;
        inflight_d    = inflight_q;
        discard_d     = discard_q;
        fifo_count_d  = fifo_count_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_wr_d     = fifo_wr_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;

        if (req_fire && !imem_rsp_valid) begin
            inflight_d = inflight_q + CntOne;
        end else if (!req_fire && imem_rsp_valid) begin
            inflight_d = inflight_q - CntOne;
        end

        if (req_fire) begin
            tag_wr_d = tag_wr_q + PtrOne;
        end
        if (imem_rsp_valid) begin
            tag_rd_d = tag_rd_q + PtrOne;
        end

        if (redirect_valid) begin
            // Everything still outstanding after this edge belongs to the old stream.
            discard_d     = discard_q + inflight_q - (imem_rsp_valid ? CntOne : '0);
            fifo_count_d  = '0;
            fifo_rd_d     = '0;
            fifo_wr_d     = '0;
            fetch_pc_d    = redirect_pc;
            fetch_error_d = (redirect_pc[1:0] != 2'b00);
        end else begin
            if (imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CntOne;
            end
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_keep) begin
                fifo_wr_d = fifo_wr_q + PtrOne;
            end
            if (instr_pop) begin
                fifo_rd_d = fifo_rd_q + PtrOne;
            end
            if (rsp_keep && !instr_pop) begin
                fifo_count_d = fifo_count_q + CntOne;
            end else if (!rsp_keep && instr_pop) begin
                fifo_count_d = fifo_count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q    <= RESET_PC;
            fetch_error_q <= 1'b0;
            inflight_q    <= '0;
            discard_q     <= '0;
            fifo_count_q  <= '0;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fetch_error_q <= fetch_error_d;
            inflight_q    <= inflight_d;
            discard_q     <= discard_d;
            fifo_count_q  <= fifo_count_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
        end
    end

    // Storage needs no reset: occupancy counters and pointers qualify every read.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc_q[tag_wr_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            fifo_data_q[fifo_wr_q] <= imem_rsp_data;
            fifo_pc_q[fifo_wr_q]   <= tag_pc_q[tag_rd_q];
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a queue-based reference model plus a latency-programmable
// in-order memory; the model is checked every cycle and pinned by hand-derived expectations.
module tb_instruction_fetch_unit;

    localparam int          Depth = 2;
    localparam logic [31:0] RstPc = 32'h0000_0000;

    logic        clk;
    logic        resetn;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_error;

    instruction_fetch_unit #(
        .RESET_PC   (RstPc),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_error    (fetch_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
    typedef struct {logic [31:0] addr; bit stale;} out_t;
    typedef struct {int due; logic [31:0] addr;} mem_t;

    ent_t        m_fifo[$];
    out_t        m_out[$];
    mem_t        mem_q[$];
    logic [31:0] m_pc;
    bit          m_err;
    logic [31:0] req_log[$];
    logic [31:0] del_log[$];
    int          cyc;
    int          lat;
    int          last_due;
    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 32'hBAD0_BAD1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory response, compare DUT to model, advance model at the edge.
    task automatic step();
        logic        rv;
        logic [31:0] rd;
        bit          rst, rdir, exp_rv, exp_iv, acc_dut, pop_dut, have_push;
        logic [31:0] rpc, acc_addr, pop_pc;
        ent_t        pe;
        out_t        e;
        mem_t        m;

        rv = 1'b0;
        rd = 32'hDEAD_BEEF;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            rv = 1'b1;
            rd = mem_word(mem_q[0].addr);
        end
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        #1;
        rst    = !resetn;
        rdir   = redirect_valid;
        rpc    = redirect_pc;
        exp_rv = !rst && !rdir && !m_err && (m_out.size() + m_fifo.size() < Depth);
        exp_iv = !rst && !m_err && (m_fifo.size() > 0);
        check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        check("instr_valid", 32'(instr_valid), 32'(exp_iv));
        if (!rst) check("fetch_error", 32'(fetch_error), 32'(m_err));
        if (exp_rv) check("req_addr", imem_req_addr, m_pc);
        if (exp_iv) begin
            check("instruction", instruction, m_fifo[0].data);
            check("instr_pc", instr_pc, m_fifo[0].pc);
        end
        acc_dut  = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        pop_dut  = instr_valid && instr_ready && !rdir;
        pop_pc   = instr_pc;

        @(posedge clk);
        if (rst) begin
            m_pc  = RstPc;
            m_err = 1'b0;
            m_fifo.delete();
            m_out.delete();
            mem_q.delete();
            last_due = 0;
        end else begin
            have_push = 1'b0;
            if (rv) begin
                void'(mem_q.pop_front());
                if (m_out.size() == 0) begin
                    check("rsp_has_request", 32'd0, 32'd1);
                end else begin
                    e = m_out.pop_front();
                    if (!e.stale && !rdir) begin
                        have_push = 1'b1;
                        pe.pc     = e.addr;
                        pe.data   = rd;
                    end
                end
            end
            if (exp_iv && instr_ready && !rdir) void'(m_fifo.pop_front());
            if (have_push) m_fifo.push_back(pe);
            if (rdir) begin
                m_fifo.delete();
                foreach (m_out[i]) m_out[i].stale = 1'b1;
                m_pc  = rpc;
                m_err = (rpc[1:0] != 2'b00);
            end else if (exp_rv && imem_req_ready) begin
                e.addr  = m_pc;
                e.stale = 1'b0;
                m_out.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            if (acc_dut) begin
                m.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                m.addr = acc_addr;
                last_due = m.due;
                mem_q.push_back(m);
                req_log.push_back(acc_addr);
            end
            if (pop_dut) del_log.push_back(pop_pc);
        end
        cyc++;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        req_log.delete();
        del_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stale_seen;
        bit found;

        resetn         = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        m_pc           = RstPc;
        m_err          = 1'b0;
        cyc            = 0;
        lat            = 1;
        last_due       = 0;
        n_cmp          = 0;
        n_err          = 0;

        @(negedge clk);
        do_reset();
        do_reset();
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst_req_addr", imem_req_addr, RstPc);
        check("rst_fetch_error", 32'(fetch_error), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);

        // Latency 1, always ready: in-order delivery from RESET_PC.
        run(10);
        check("t1_pc0", q_at(del_log, 0), 32'h0);
        check("t1_pc1", q_at(del_log, 1), 32'h4);
        check("t1_pc2", q_at(del_log, 2), 32'h8);
        check("t1_pc3", q_at(del_log, 3), 32'hC);

        // Decode stalled: credit limit caps accepted requests at the buffer depth.
        do_reset();
        instr_ready = 1'b0;
        run(8);
        check("t2_accepted", 32'(req_log.size()), 32'd2);
        check("t2_req_stall", 32'(imem_req_valid), 32'd0);
        instr_ready = 1'b1;
        run(6);
        check("t2_pc0", q_at(del_log, 0), 32'h0);
        check("t2_pc1", q_at(del_log, 1), 32'h4);
        check("t2_resume", q_at(req_log, 2), 32'h8);

        // Latency 3, redirect with two reads in flight: both are squashed.
        do_reset();
        lat = 3;
        run(2);
        check("t3_inflight", 32'(req_log.size()), 32'd2);
        redirect(32'h0000_0100);
        run(12);
        check("t3_first", q_at(del_log, 0), 32'h100);
        stale_seen = 1'b0;
        foreach (del_log[i]) if (del_log[i] == 32'h0 || del_log[i] == 32'h4) stale_seen = 1'b1;
        check("t3_no_stale", 32'(stale_seen), 32'd0);

        // Misaligned redirect halts fetch; an aligned one recovers.
        redirect(32'h0000_0102);
        run(5);
        check("t4_err", 32'(fetch_error), 32'd1);
        check("t4_req_off", 32'(imem_req_valid), 32'd0);
        check("t4_instr_off", 32'(instr_valid), 32'd0);
        del_log.delete();
        redirect(32'h0000_0200);
        imem_req_ready = 1'b0;
        run(3);
        imem_req_ready = 1'b1;
        run(14);
        check("t4_recover", q_at(del_log, 0), 32'h200);
        check("t4_err_clear", 32'(fetch_error), 32'd0);

        // Redirect while a head is popped and a response lands in the same cycle.
        lat = 1;
        run(4);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid && mem_q.size() > 0 && mem_q[0].due == cyc) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check("t5_found", 32'(found), 32'd1);
        del_log.delete();
        redirect(32'h0000_0300);
        check("t5_rsp_seen", 32'(imem_rsp_valid), 32'd1);
        check("t5_flushed", 32'(instr_valid), 32'd0);
        check("t5_pop_ignored", 32'(del_log.size()), 32'd0);
        run(6);
        check("t5_next", q_at(del_log, 0), 32'h300);

        // Address wrap, then reset out of an error state.
        run(2);
        req_log.delete();
        redirect(32'hFFFF_FFFC);
        run(6);
        check("t6_wrap0", q_at(req_log, 0), 32'hFFFF_FFFC);
        check("t6_wrap1", q_at(req_log, 1), 32'h0000_0000);
        redirect(32'h0000_0041);
        run(2);
        check("t6_err", 32'(fetch_error), 32'd1);
        do_reset();
        #1;
        check("t6_rst_err", 32'(fetch_error), 32'd0);
        check("t6_rst_valid", 32'(imem_req_valid), 32'd1);
        check("t6_rst_addr", imem_req_addr, RstPc);
        run(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
